// File: rtl/game_pkg.sv
// Shared constants and types for the key input stage and menu logic.
package game_pkg;

  // DE1-SoC pushbutton roles
  localparam int unsigned KEY_SELECT = 0;
  localparam int unsigned KEY_PREV   = 1;
  localparam int unsigned KEY_START  = 2;
  localparam int unsigned KEY_BACK   = 3;

  // Default timing at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE     = 5000000;   // 0.1 s

  // Per-key debounce state
  typedef enum logic [1:0] {
    StUp,
    StWaitDn,
    StDown,
    StWaitUp
  } db_state_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_1.sv
// Single-key conditioner: 2-flop synchroniser, debounce FSM and auto-repeat counter.
module key_debounce_1
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,      // raw, active-low, asynchronous
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic released,
  output logic rpt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RW = $clog2(umax(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic      sync1_q, sync2_q;
  logic      s;
  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic      first_q, first_d;  // next repeat uses REPEAT_DELAY rather than REPEAT_RATE
  logic      level_q, level_d;
  logic      press_q, press_d;
  logic      rel_q, rel_d;
  logic      rpt_q, rpt_d;
  logic      held;

  // Synchroniser; resets to the released level so reset release makes no edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Debounce next-state: a change needs DEBOUNCE_CYCLES consecutive samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      StUp: begin
        if (s) begin
          state_d = StWaitDn;
          cnt_d   = CW'(1);
        end
      end
      StWaitDn: begin
        if (!s) begin
          state_d = StUp;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StDown;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDown: begin
        if (!s) begin
          state_d = StWaitUp;
          cnt_d   = CW'(1);
        end
      end
      StWaitUp: begin
        if (s) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = StUp;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StUp;
        cnt_d   = '0;
      end
    endcase
  end

  assign held = (state_q == StDown) || (state_q == StWaitUp);

  // Auto-repeat next-state; release acceptance wins over a coinciding repeat
  always_comb begin
    rcnt_d  = rcnt_q;
    first_d = first_q;
    rpt_d   = 1'b0;
    if (!held || rel_d || !repeat_en) begin
      rcnt_d  = '0;
      first_d = 1'b1;
    end else if (rcnt_q == (first_q ? DELAY_LAST : RATE_LAST)) begin
      rpt_d   = 1'b1;
      rcnt_d  = '0;
      first_d = 1'b0;
    end else begin
      rcnt_d = rcnt_q + RW'(1);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StUp;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b1;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level    = level_q;
  assign press    = press_q;
  assign released = rel_q;
  assign rpt      = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton input stage: NKEYS independent conditioners plus an any-key press pulse.
module key_conditioner
  import game_pkg::*;
#(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [NKEYS-1:0] KEY,
  input  logic [NKEYS-1:0] repeat_en,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat,
  output logic             any_press
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_1 #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_key (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .key_n     (KEY[i]),
      .repeat_en (repeat_en[i]),
      .level     (key_level[i]),
      .press     (key_press[i]),
      .released  (key_release[i]),
      .rpt       (key_repeat[i])
    );
  end

  // key_press is already registered, so the OR lands in the same cycle
  assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with an expected-pulse scoreboard.
module tb_key_conditioner;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [3:0] repeat_en;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       any_press;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] lvl;
  } ev_t;

  ev_t q[$];
  ev_t mon_ev;
  int  p;
  int  rq;

  key_conditioner #(
    .NKEYS           (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (5)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .KEY         (key_n),
    .repeat_en   (repeat_en),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] rp, input logic [3:0] lvl);
    ev_t e;
    e.cyc   = c;
    e.press = pr;
    e.rel   = rl;
    e.rpt   = rp;
    e.lvl   = lvl;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every pulse cycle must match the head of the scoreboard, level included
  always @(negedge clk) begin
    if (resetn) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_pulse_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if ((key_press | key_release | key_repeat) != 4'b0 || any_press) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          mon_ev = q.pop_front();
          chk("pulses", {key_press, key_release, key_repeat, any_press, key_level},
              {mon_ev.press, mon_ev.rel, mon_ev.rpt, |mon_ev.press, mon_ev.lvl});
        end else begin
          chk("unexpected_pulse", {key_press, key_release, key_repeat, any_press}, 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn    = 1'b0;
    key_n     = 4'hF;
    repeat_en = 4'h0;
    tick(3);
    chk("reset_outputs", {key_level, key_press, key_release, key_repeat, any_press}, 32'h0);
    resetn = 1'b1;
    tick(12);
    chk("idle_level", key_level, 4'b0000);

    // 1: clean press and release on key 0
    key_n[KEY_SELECT] = 1'b0;
    push(cyc + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    tick(12);
    chk("t1_level_pressed", key_level, 4'b0001);
    key_n[KEY_SELECT] = 1'b1;
    push(cyc + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tick(5);
    chk("t1_level_mid_release", key_level, 4'b0001);
    tick(7);
    chk("t1_level_released", key_level, 4'b0000);

    // 2: bounce rejection on key 1, then a genuine press
    key_n[KEY_PREV] = 1'b0; tick(5);
    key_n[KEY_PREV] = 1'b1; tick(1);
    key_n[KEY_PREV] = 1'b0; tick(5);
    key_n[KEY_PREV] = 1'b1; tick(2);
    tick(12);
    chk("t2_bounce_level", key_level, 4'b0000);
    key_n[KEY_PREV] = 1'b0;
    push(cyc + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tick(12);
    chk("t2_level_pressed", key_level, 4'b0010);

    // 6: release of key 1 with 3-cycle bounces
    key_n[KEY_PREV] = 1'b1; tick(3);
    key_n[KEY_PREV] = 1'b0; tick(3);
    key_n[KEY_PREV] = 1'b1; tick(3);
    key_n[KEY_PREV] = 1'b0; tick(3);
    chk("t6_level_during_bounce", key_level, 4'b0010);
    key_n[KEY_PREV] = 1'b1;
    push(cyc + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    tick(6);
    chk("t6_level_mid", key_level, 4'b0010);
    tick(6);
    chk("t6_level_released", key_level, 4'b0000);

    // 3a: auto-repeat on key 2, released 60 cycles after the press
    repeat_en[KEY_START] = 1'b1;
    key_n[KEY_START] = 1'b0;
    p = cyc + 10;
    push(p, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    for (int k = 0; k < 10; k++) push(p + 20 + 5 * k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    tick(70);
    key_n[KEY_START] = 1'b1;
    push(p + 70, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    tick(15);
    chk("t3_level_released", key_level, 4'b0000);

    // 3b: repeat_en dropped after the first repeat, then re-enabled while held
    key_n[KEY_START] = 1'b0;
    p = cyc + 10;
    push(p, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    push(p + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    tick(32);
    repeat_en[KEY_START] = 1'b0;
    tick(20);
    chk("t3_level_held_no_repeat", key_level, 4'b0100);
    rq = cyc;
    repeat_en[KEY_START] = 1'b1;
    push(rq + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(rq + 25, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(rq + 30, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    tick(22);
    key_n[KEY_START] = 1'b1;
    push(rq + 32, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    tick(15);
    repeat_en = 4'h0;
    chk("t3b_level_released", key_level, 4'b0000);

    // 4: keys 0 and 3 fall together; release only key 0
    key_n = 4'b0110;
    push(cyc + 10, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    tick(12);
    chk("t4_level_both", key_level, 4'b1001);
    key_n[KEY_SELECT] = 1'b1;
    push(cyc + 10, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
    tick(12);
    chk("t4_level_key3_only", key_level, 4'b1000);

    // 5: reset while key 0 is mid-debounce (cnt = 5) and key 3 is held down
    key_n[KEY_SELECT] = 1'b0;
    tick(7);
    #2 resetn = 1'b0;
    #1 chk("t5_async_reset", {key_level, key_press, key_release, key_repeat, any_press}, 32'h0);
    tick(2);
    resetn = 1'b1;
    push(cyc + 10, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    tick(9);
    chk("t5_level_before_accept", key_level, 4'b0000);
    tick(3);
    chk("t5_level_after_accept", key_level, 4'b1001);

    // Release everything and make sure the scoreboard drained
    key_n = 4'hF;
    push(cyc + 10, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    tick(14);
    chk("final_level", key_level, 4'b0000);
    chk("queue_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
